vga_sync_rx: RTL and testbench

//  Receive side of the 640x480 VGA timing interface (25 MHz pixel clock).

---
 rtl/vga_sync_rx.sv | 211 +++++++++++++++++++++
 tb/tb_vga_sync_rx.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_rx.sv
// vga_sync_rx: receive side of the VGA timing interface.
// Registers the active-low syncs from a timing generator running on the same
// clk, recovers column/row/video_on two clocks behind the generator, checks
// every sync edge against the programmed timing and reports lock, timing
// errors, the measured line length and the measured lines per frame.
module vga_sync_rx #(
    parameter int H_PIXEL     = 640,
    parameter int HSYNC_START = 659,
    parameter int HSYNC_END   = 755,
    parameter int H_MAX       = 799,
    parameter int V_PIXEL     = 480,
    parameter int VSYNC_START = 493,
    parameter int VSYNC_END   = 494,
    parameter int V_MAX       = 524,
    parameter int LOCK_FRAMES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       h_sync_n,
    input  logic       v_sync_n,
    output logic [9:0] rx_col,
    output logic [9:0] rx_row,
    output logic       rx_video_on,
    output logic       locked,
    output logic       frame_start,
    output logic       sync_err,
    output logic [9:0] line_len,
    output logic [9:0] frame_lines
);

    localparam logic [9:0] H_PIXEL_C  = 10'(H_PIXEL);
    localparam logic [9:0] HS_C       = 10'(HSYNC_START);
    localparam logic [9:0] HE1_C      = 10'(HSYNC_END + 1);
    localparam logic [9:0] H_MAX_C    = 10'(H_MAX);
    localparam logic [9:0] V_PIXEL_C  = 10'(V_PIXEL);
    localparam logic [9:0] VS_C       = 10'(VSYNC_START);
    localparam logic [9:0] VE1_C      = 10'(VSYNC_END + 1);
    localparam logic [9:0] V_MAX_C    = 10'(V_MAX);
    localparam logic [7:0] LOCK_C     = 8'(LOCK_FRAMES);
    localparam logic [9:0] SAT_C      = 10'h3FF;

    // SEARCH: follow h_sync only, wait for a v_sync fall.
    // VERIFY: check every edge, count clean frames.
    // LOCKED: keep checking, video_on and frame_start enabled.
    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t     state;
    state_t     state_next;

    logic       h_q, h_prev, v_q, v_prev;
    logic       h_fall, h_rise, v_fall, v_rise;
    logic [9:0] col_next, row_next;
    logic       h_err, v_err, v_at_start, mismatch;
    logic [7:0] frame_cnt;
    logic [7:0] frame_cnt_inc;
    logic [9:0] hcnt, vcnt;
    logic [9:0] hcnt_inc, vcnt_inc;

    // Edge detection on the once-registered syncs; idle-high reset avoids a false edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_q    <= 1'b1;
            h_prev <= 1'b1;
            v_q    <= 1'b1;
            v_prev <= 1'b1;
        end else begin
            h_q    <= h_sync_n;
            h_prev <= h_q;
            v_q    <= v_sync_n;
            v_prev <= v_q;
        end
    end

    assign h_fall = h_prev & ~h_q;
    assign h_rise = ~h_prev & h_q;
    assign v_fall = v_prev & ~v_q;
    assign v_rise = ~v_prev & v_q;

    // A detected edge belongs to the generator position one clk ahead of rx_col/rx_row,
    // so all checks are made against the next counter position.
    always_comb begin
        col_next = (rx_col == H_MAX_C) ? 10'd0 : rx_col + 10'd1;
        row_next = rx_row;
        if (rx_col == H_MAX_C) begin
            row_next = (rx_row == V_MAX_C) ? 10'd0 : rx_row + 10'd1;
        end
        v_at_start = (col_next == 10'd0) && (row_next == VS_C);
        h_err = (h_fall != (col_next == HS_C)) ||
                (h_rise && (col_next != HE1_C));
        v_err = (v_fall != v_at_start) ||
                (v_rise && !((col_next == 10'd0) && (row_next == VE1_C)));
        mismatch = (state != SEARCH) && (h_err || v_err);
        frame_cnt_inc = frame_cnt + 8'd1;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SEARCH;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a mismatch always wins over a coincident clean event.
    always_comb begin
        state_next = state;
        case (state)
            SEARCH: begin
                if (v_fall) begin
                    state_next = VERIFY;
                end
            end
            VERIFY: begin
                if (mismatch) begin
                    state_next = SEARCH;
                end else if (v_fall && (frame_cnt_inc == LOCK_C)) begin
                    state_next = LOCKED;
                end
            end
            LOCKED: begin
                if (mismatch) begin
                    state_next = SEARCH;
                end
            end
            default: state_next = SEARCH;
        endcase
    end

    // FSM-derived outputs.
    always_comb begin
        locked      = (state == LOCKED);
        rx_video_on = locked && (rx_col < H_PIXEL_C) && (rx_row < V_PIXEL_C);
        frame_start = locked && (rx_col == 10'd0) && (rx_row == 10'd0);
    end

    // Recovered position: realigned by sync falls in SEARCH, free-running otherwise.
    always_ff @(posedge clk) begin
        if (rst || mismatch) begin
            rx_col <= 10'd0;
            rx_row <= 10'd0;
        end else if (state == SEARCH) begin
            if (v_fall) begin
                rx_col <= 10'd0;
                rx_row <= VS_C;
            end else if (h_fall) begin
                rx_col <= HS_C;
                rx_row <= 10'd0;
            end else begin
                rx_col <= col_next;
                rx_row <= 10'd0;
            end
        end else begin
            rx_col <= col_next;
            rx_row <= row_next;
        end
    end

    // Clean-frame counter used to qualify lock.
    always_ff @(posedge clk) begin
        if (rst || mismatch || (state == SEARCH)) begin
            frame_cnt <= 8'd0;
        end else if ((state == VERIFY) && v_fall) begin
            frame_cnt <= frame_cnt_inc;
        end
    end

    // Error pulse, registered so it lines up with locked dropping.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_err <= 1'b0;
        end else begin
            sync_err <= mismatch;
        end
    end

    assign hcnt_inc = (hcnt == SAT_C) ? hcnt : hcnt + 10'd1;
    assign vcnt_inc = (vcnt == SAT_C) ? vcnt : vcnt + 10'd1;

    // Line length: clocks between consecutive h_sync falls, saturating.
    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt     <= 10'd0;
            line_len <= 10'd0;
        end else if (h_fall) begin
            hcnt     <= 10'd1;
            line_len <= hcnt;
        end else begin
            hcnt     <= hcnt_inc;
        end
    end

    // Lines per frame: h_sync falls between consecutive v_sync falls, saturating.
    // A coincident h_sync fall is counted in the new frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            vcnt        <= 10'd0;
            frame_lines <= 10'd0;
        end else if (v_fall) begin
            vcnt        <= h_fall ? 10'd1 : 10'd0;
            frame_lines <= vcnt;
        end else if (h_fall) begin
            vcnt        <= vcnt_inc;
        end
    end

endmodule

// File: tb/tb_vga_sync_rx.sv
// tb_vga_sync_rx: drives vga_sync_rx from a small behavioural timing generator
// (reduced geometry so several frames fit in a short run). The generator pushes
// its col/row/video_on into exp_q each clk; a monitor pops two clks later and
// compares the recovered position whenever the DUT reports lock.
module tb_vga_sync_rx;

    localparam int H_PIXEL     = 16;
    localparam int HSYNC_START = 18;
    localparam int HSYNC_END   = 20;
    localparam int H_MAX       = 24;
    localparam int V_PIXEL     = 8;
    localparam int VSYNC_START = 10;
    localparam int VSYNC_END   = 11;
    localparam int V_MAX       = 13;
    localparam int LOCK_FRAMES = 2;
    localparam int LINE        = H_MAX + 1;
    localparam int FRAME       = LINE * (V_MAX + 1);

    logic       clk;
    logic       rst;
    logic       h_sync_n;
    logic       v_sync_n;
    logic [9:0] rx_col;
    logic [9:0] rx_row;
    logic       rx_video_on;
    logic       locked;
    logic       frame_start;
    logic       sync_err;
    logic [9:0] line_len;
    logic [9:0] frame_lines;

    int n_checks = 0;
    int n_errors = 0;

    // generator controls and state
    int gen_col = 0;
    int gen_row = 0;
    int gen_h_max = H_MAX;
    bit gen_en = 1'b1;
    int h_extra = 0;
    int gen_vfall_cnt = 0;
    int gen_since_vfall = 0;

    logic [20:0] exp_q[$];
    logic [20:0] mon_e;

    vga_sync_rx #(
        .H_PIXEL(H_PIXEL), .HSYNC_START(HSYNC_START), .HSYNC_END(HSYNC_END),
        .H_MAX(H_MAX), .V_PIXEL(V_PIXEL), .VSYNC_START(VSYNC_START),
        .VSYNC_END(VSYNC_END), .V_MAX(V_MAX), .LOCK_FRAMES(LOCK_FRAMES)
    ) dut (
        .clk(clk), .rst(rst), .h_sync_n(h_sync_n), .v_sync_n(v_sync_n),
        .rx_col(rx_col), .rx_row(rx_row), .rx_video_on(rx_video_on),
        .locked(locked), .frame_start(frame_start), .sync_err(sync_err),
        .line_len(line_len), .frame_lines(frame_lines)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // present the syncs for the current generator position and record the expectation
    task present();
        logic von;
        h_sync_n = !(gen_en && gen_col >= HSYNC_START && gen_col <= HSYNC_END + h_extra);
        v_sync_n = !(gen_en && gen_row >= VSYNC_START && gen_row <= VSYNC_END);
        von = (gen_col < H_PIXEL) && (gen_row < V_PIXEL);
        exp_q.push_back({10'(gen_col), 10'(gen_row), von});
        if (gen_en && gen_col == 0 && gen_row == VSYNC_START) begin
            gen_vfall_cnt++;
            gen_since_vfall = 0;
        end else begin
            gen_since_vfall++;
        end
    endtask

    // timing generator driver
    initial begin
        present();
        forever begin
            @(posedge clk);
            #1;
            if (gen_col >= gen_h_max) begin
                gen_col = 0;
                gen_row = (gen_row == V_MAX) ? 0 : gen_row + 1;
            end else begin
                gen_col++;
            end
            present();
        end
    end

    // scoreboard monitor: steady-state queue depth of 3 gives the 2-clk delay
    always @(negedge clk) begin
        if (exp_q.size() >= 3) begin
            mon_e = exp_q.pop_front();
            if (locked === 1'b1 && rst === 1'b0) begin
                chk("align_col", rx_col, mon_e[20:11]);
                chk("align_row", rx_row, mon_e[10:1]);
                chk("align_video_on", rx_video_on, mon_e[0]);
                chk("align_frame_start", frame_start,
                    (mon_e[20:11] == 10'd0 && mon_e[10:1] == 10'd0) ? 1 : 0);
            end
        end
    end

    task automatic wait_gen(input int col, input int row, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (gen_col == col && gen_row == row) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_locked(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (locked === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_err(input int budget, output bit ok, output bit prev_locked);
        ok = 1'b0;
        prev_locked = locked;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (sync_err === 1'b1) begin
                ok = 1'b1;
                break;
            end
            prev_locked = locked;
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_rx_col"}, rx_col, 0);
        chk({tag, "_rx_row"}, rx_row, 0);
        chk({tag, "_rx_video_on"}, rx_video_on, 0);
        chk({tag, "_locked"}, locked, 0);
        chk({tag, "_frame_start"}, frame_start, 0);
        chk({tag, "_sync_err"}, sync_err, 0);
        chk({tag, "_line_len"}, line_len, 0);
        chk({tag, "_frame_lines"}, frame_lines, 0);
    endtask

    // watchdog
    initial begin
        #(80000 * 10);
        $display("FAIL watchdog: simulation did not complete in time");
        n_errors++;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

    // directed test sequence
    initial begin
        bit ok;
        bit prev_locked;
        bit saw_lock;
        int snap;
        int last_fs;
        int fs_cnt;
        int err_cnt;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        snap = gen_vfall_cnt;

        // 1: acquire lock on the third v_sync fall, two clks after it is presented
        wait_locked(6 * FRAME, ok);
        chk("t1_lock_seen", ok, 1);
        chk("t1_lock_vfalls", gen_vfall_cnt - snap, 3);
        chk("t1_lock_latency_le3", (gen_since_vfall <= 3) ? 1 : 0, 1);
        chk("t1_line_len", line_len, LINE);
        chk("t1_frame_lines", frame_lines, V_MAX + 1);

        // 2: three locked frames, frame_start period, no errors
        last_fs = -1;
        fs_cnt = 0;
        err_cnt = 0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            @(negedge clk);
            if (sync_err === 1'b1) err_cnt++;
            if (frame_start === 1'b1) begin
                if (last_fs >= 0) chk("t2_frame_start_period", i - last_fs, FRAME);
                last_fs = i;
                fs_cnt++;
            end
        end
        chk("t2_frame_start_count", fs_cnt, 3);
        chk("t2_sync_err_count", err_cnt, 0);
        chk("t2_still_locked", locked, 1);

        // 3: h_sync held low one extra clk on one line
        wait_gen(0, 2, 2 * FRAME, ok);
        chk("t3_gen_reached", ok, 1);
        h_extra = 1;
        wait_gen(HSYNC_END + 3, 2, LINE, ok);
        h_extra = 0;
        wait_err(LINE, ok, prev_locked);
        chk("t3_sync_err_seen", ok, 1);
        chk("t3_locked_before_err", prev_locked, 1);
        chk("t3_locked_at_err", locked, 0);
        chk("t3_video_on_at_err", rx_video_on, 0);
        snap = gen_vfall_cnt;
        @(negedge clk);
        chk("t3_sync_err_width", sync_err, 0);
        wait_locked(5 * FRAME, ok);
        chk("t3_relock_seen", ok, 1);
        chk("t3_relock_vfalls", gen_vfall_cnt - snap, 3);

        // 4: syncs stopped while locked
        wait_gen(0, 1, 2 * FRAME, ok);
        chk("t4_gen_reached", ok, 1);
        gen_en = 1'b0;
        wait_err(2 * LINE, ok, prev_locked);
        chk("t4_sync_err_seen", ok, 1);
        chk("t4_locked_at_err", locked, 0);
        err_cnt = 0;
        saw_lock = 1'b0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            @(negedge clk);
            if (sync_err === 1'b1) err_cnt++;
            if (locked === 1'b1) saw_lock = 1'b1;
        end
        chk("t4_no_relock", saw_lock, 0);
        chk("t4_no_further_err", err_cnt, 0);

        // 5: line one clk too long: one error per VERIFY attempt, never locks
        wait_gen(0, 0, 2 * FRAME, ok);
        chk("t5_gen_reached", ok, 1);
        gen_h_max = H_MAX + 1;
        gen_en = 1'b1;
        err_cnt = 0;
        saw_lock = 1'b0;
        for (int i = 0; i < 5 * (LINE + 1) * (V_MAX + 1); i++) begin
            @(negedge clk);
            if (sync_err === 1'b1) err_cnt++;
            if (locked === 1'b1) saw_lock = 1'b1;
        end
        chk("t5_never_locked", saw_lock, 0);
        chk("t5_sync_err_count", err_cnt, 5);
        chk("t5_line_len", line_len, LINE + 1);
        chk("t5_frame_lines", frame_lines, V_MAX + 1);

        // 6: reset pulse mid-frame while locked
        wait_gen(0, 0, 2 * FRAME, ok);
        chk("t6_gen_reached", ok, 1);
        gen_h_max = H_MAX;
        wait_locked(6 * FRAME, ok);
        chk("t6_lock_seen", ok, 1);
        wait_gen(3, 5, 2 * FRAME, ok);
        chk("t6_gen_midframe", ok, 1);
        chk("t6_locked_before_rst", locked, 1);
        rst = 1'b1;
        @(negedge clk);
        check_zero("t6_after_rst");
        rst = 1'b0;
        snap = gen_vfall_cnt;
        wait_locked(6 * FRAME, ok);
        chk("t6_relock_seen", ok, 1);
        chk("t6_relock_vfalls", gen_vfall_cnt - snap, 3);
        repeat (5) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
